// File: rtl/hex_step_counter.sv
// hex_step_counter
//   Button-driven hex digit source. Debounces an up and a down push button,
//   steps a 4-bit value once per press, auto-repeats while a button is held,
//   and supports a synchronous direct load from switches.
//
// Ports
//   CLOCK       in   board clock, single clock domain
//   RESET       in   synchronous active-high reset
//   iUp         in   raw up button (1 = pressed), asynchronous
//   iDown       in   raw down button (1 = pressed), asynchronous
//   iLoad       in   synchronous load strobe, overrides any step
//   iLoadValue  in   [3:0] value loaded while iLoad = 1
//   oHex        out  [3:0] current digit (registered), drives the ROM address
//   oStep       out  one-cycle pulse when oHex changed because of a step
module hex_step_counter #(
  parameter int unsigned DEBOUNCE_CYCLES = 100000,
  parameter int unsigned REPEAT_DELAY    = 5000000,
  parameter int unsigned REPEAT_PERIOD   = 1000000
) (
  input  logic       CLOCK,
  input  logic       RESET,
  input  logic       iUp,
  input  logic       iDown,
  input  logic       iLoad,
  input  logic [3:0] iLoadValue,
  output logic [3:0] oHex,
  output logic       oStep
);

  localparam int unsigned DbW   = $clog2(DEBOUNCE_CYCLES);
  localparam int unsigned TmMax = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int unsigned TmW   = (TmMax > 2) ? $clog2(TmMax) : 1;

  localparam logic [DbW-1:0] DbLast = DbW'(DEBOUNCE_CYCLES - 1);
  localparam logic [TmW-1:0] RdLast = TmW'(REPEAT_DELAY - 1);
  localparam logic [TmW-1:0] RpLast = TmW'(REPEAT_PERIOD - 1);

  typedef enum logic [1:0] {StIdle, StDelay, StRepeat} state_e;

  // Index 0 = up button, index 1 = down button.
  logic [1:0]     r_sync1;
  logic [1:0]     r_sync2;
  logic [1:0]     r_stable;
  logic [1:0]     r_prev;
  logic [DbW-1:0] r_db_cnt [2];

  state_e         r_state;
  state_e         w_state_d;
  logic [TmW-1:0] r_timer;
  logic [TmW-1:0] w_timer_d;
  logic           r_dir;
  logic           w_dir_d;
  logic [3:0]     r_hex;
  logic [3:0]     w_hex_d;
  logic           r_step;
  logic           w_step;

  logic           w_up_rise;
  logic           w_dn_rise;
  logic           w_held;

  // Synchronizers, debouncers and edge-detect history.
  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      r_sync1  <= '0;
      r_sync2  <= '0;
      r_stable <= '0;
      r_prev   <= '0;
      for (int i = 0; i < 2; i++) begin
        r_db_cnt[i] <= '0;
      end
    end else begin
      r_sync1 <= {iDown, iUp};
      r_sync2 <= r_sync1;
      r_prev  <= r_stable;
      for (int i = 0; i < 2; i++) begin
        if (r_sync2[i] == r_stable[i]) begin
          r_db_cnt[i] <= '0;
        end else if (r_db_cnt[i] == DbLast) begin
          r_stable[i] <= r_sync2[i];
          r_db_cnt[i] <= '0;
        end else begin
          r_db_cnt[i] <= r_db_cnt[i] + DbW'(1);
        end
      end
    end
  end

  assign w_up_rise = r_stable[0] & ~r_prev[0];
  assign w_dn_rise = r_stable[1] & ~r_prev[1];
  // The latched button must stay pressed and the other one must stay released.
  assign w_held    = r_dir ? (r_stable[0] & ~r_stable[1]) : (r_stable[1] & ~r_stable[0]);

  always_comb begin
    w_state_d = r_state;
    w_timer_d = r_timer;
    w_dir_d   = r_dir;
    w_step    = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (w_up_rise && !r_stable[1]) begin
          w_step    = 1'b1;
          w_dir_d   = 1'b1;
          w_timer_d = '0;
          w_state_d = StDelay;
        end else if (w_dn_rise && !r_stable[0]) begin
          w_step    = 1'b1;
          w_dir_d   = 1'b0;
          w_timer_d = '0;
          w_state_d = StDelay;
        end
      end
      StDelay: begin
        if (!w_held) begin
          w_timer_d = '0;
          w_state_d = StIdle;
        end else if (r_timer == RdLast) begin
          w_step    = 1'b1;
          w_timer_d = '0;
          w_state_d = StRepeat;
        end else begin
          w_timer_d = r_timer + TmW'(1);
        end
      end
      StRepeat: begin
        if (!w_held) begin
          w_timer_d = '0;
          w_state_d = StIdle;
        end else if (r_timer == RpLast) begin
          w_step    = 1'b1;
          w_timer_d = '0;
        end else begin
          w_timer_d = r_timer + TmW'(1);
        end
      end
      default: begin
        w_timer_d = '0;
        w_state_d = StIdle;
      end
    endcase

    // Load wins over any step; returning to idle means a held button needs a
    // fresh press before it steps again.
    if (iLoad) begin
      w_step    = 1'b0;
      w_timer_d = '0;
      w_state_d = StIdle;
    end

    if (iLoad) begin
      w_hex_d = iLoadValue;
    end else if (w_step) begin
      w_hex_d = w_dir_d ? (r_hex + 4'd1) : (r_hex - 4'd1);
    end else begin
      w_hex_d = r_hex;
    end
  end

  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      r_state <= StIdle;
      r_timer <= '0;
      r_dir   <= 1'b0;
      r_hex   <= 4'd0;
      r_step  <= 1'b0;
    end else begin
      r_state <= w_state_d;
      r_timer <= w_timer_d;
      r_dir   <= w_dir_d;
      r_hex   <= w_hex_d;
      r_step  <= w_step;
    end
  end

  assign oHex  = r_hex;
  assign oStep = r_step;

endmodule
